// File: rtl/code_link_pkg.sv
// Shared definitions for the code-match serial link (transmitter and receiver).
package code_link_pkg;

   // Frame sequencing states.
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } link_state_t;

   // Line levels for the framing bits.
   localparam logic START_LVL = 1'b0;
   localparam logic STOP_LVL  = 1'b1;
   localparam logic IDLE_LVL  = 1'b1;

   // Parity sense used on the link.
   typedef enum logic {
      EVEN = 1'b0,
      ODD  = 1'b1
   } parity_mode_t;

   localparam parity_mode_t PARITY_MODE = EVEN;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/code_tx_bit_timer.sv
// Per-bit tick generator: counts 0..DIV-1 and flags the last clock of each bit.
module bit_timer
   import code_link_pkg::*;
#(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);

   localparam int TW = cnt_width(DIV);
   localparam logic [TW-1:0] LAST = TW'(DIV - 1);

   logic [TW-1:0] cnt;

   // Bit-period counter; held at zero while cleared, wraps after the last clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (clr || tick)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/code_tx.sv
// Serial transmitter: start bit, data LSB-first, parity, stop bit.
module code_tx
   import code_link_pkg::*;
#(
   parameter int WIDTH = 2,
   parameter int DIV   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] code_in,
   input  logic             code_valid,
   output logic             code_ready,
   output logic             tx_line,
   output logic             busy,
   output logic             done
);

   localparam int IW = cnt_width(WIDTH);
   localparam logic [IW-1:0] LAST_BIT = IW'(WIDTH - 1);

   link_state_t      state, state_nx;
   logic [WIDTH-1:0] shift_reg, shift_nx;
   logic             par, par_nx;
   logic [IW-1:0]    idx, idx_nx;
   logic             tick;
   logic             timer_clr;

   // Timer is parked at zero in IDLE so every frame starts on a fresh bit period.
   assign timer_clr = (state == IDLE);

   bit_timer #(.DIV(DIV)) u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (timer_clr),
      .tick  (tick)
   );

   // State and datapath registers; reset drops straight back to IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         shift_reg <= '0;
         par       <= 1'b0;
         idx       <= '0;
      end else begin
         state     <= state_nx;
         shift_reg <= shift_nx;
         par       <= par_nx;
         idx       <= idx_nx;
      end
   end

   // Next-state and line decode; tx_line depends only on registered state.
   always_comb begin
      state_nx = state;
      shift_nx = shift_reg;
      par_nx   = par;
      idx_nx   = idx;
      tx_line  = IDLE_LVL;
      done     = 1'b0;
      case (state)
         IDLE: begin
            if (code_valid) begin
               shift_nx = code_in;
               par_nx   = (^code_in) ^ (PARITY_MODE == ODD);
               idx_nx   = '0;
               state_nx = START;
            end
         end
         START: begin
            tx_line = START_LVL;
            if (tick) state_nx = DATA;
         end
         DATA: begin
            tx_line = shift_reg[0];
            if (tick) begin
               shift_nx = shift_reg >> 1;
               if (idx == LAST_BIT) begin
                  idx_nx   = '0;
                  state_nx = PARITY;
               end else begin
                  idx_nx = idx + 1'b1;
               end
            end
         end
         PARITY: begin
            tx_line = par;
            if (tick) state_nx = STOP;
         end
         STOP: begin
            tx_line = STOP_LVL;
            done    = tick;
            if (tick) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign code_ready = (state == IDLE);
   assign busy       = (state != IDLE);

endmodule

// File: tb/tb_code_tx.sv
// Scoreboard bench for code_tx: stimulus queues expected frames, a monitor checks the line.
module tb_code_tx;

   localparam int WIDTH = 2;
   localparam int DIV   = 4;
   localparam int FBITS = WIDTH + 3;
   localparam int FCYC  = FBITS * DIV;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [WIDTH-1:0] code_in = '0;
   logic             code_valid = 1'b0;
   logic             code_ready;
   logic             tx_line;
   logic             busy;
   logic             done;

   int checks = 0;
   int failures = 0;
   int unsigned cyc = 0;

   logic [FBITS-1:0] exp_q[$];
   logic             mon_act = 1'b0;
   int               mon_idx = 0;
   logic [FBITS-1:0] mon_exp;

   code_tx #(.WIDTH(WIDTH), .DIV(DIV)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .code_in    (code_in),
      .code_valid (code_valid),
      .code_ready (code_ready),
      .tx_line    (tx_line),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Line bits of a frame, in transmit order: start, data LSB-first, even parity, stop.
   function automatic logic [FBITS-1:0] frame_of(input logic [WIDTH-1:0] c);
      logic [FBITS-1:0] f;
      f[0] = 1'b0;
      for (int i = 0; i < WIDTH; i++) f[i+1] = c[i];
      f[WIDTH+1] = (($countones(c) % 2) == 1);
      f[WIDTH+2] = 1'b1;
      return f;
   endfunction

   // One clock of stimulus; a handshake queues the expected frame.
   task automatic drive(input logic v, input logic [WIDTH-1:0] c, output logic acc);
      @(negedge clk);
      code_valid = v;
      code_in    = c;
      acc        = v && code_ready;
      if (acc) exp_q.push_back(frame_of(c));
   endtask

   task automatic idle(input int n);
      logic acc;
      for (int k = 0; k < n; k++) drive(1'b0, WIDTH'($urandom), acc);
   endtask

   // Hold code_valid until accepted; t is the cycle number of the accepting edge's lead-in.
   task automatic send(input logic [WIDTH-1:0] c, output int unsigned t);
      logic acc = 1'b0;
      for (int k = 0; k < 100; k++) begin
         drive(1'b1, c, acc);
         if (acc) break;
      end
      chk("accept_timeout", acc, 1);
      t = cyc;
   endtask

   task automatic wait_done(input int unsigned t0);
      logic acc = 1'b0;
      for (int k = 0; k < 4 * FCYC; k++) begin
         drive(1'b0, '0, acc);
         if (done) break;
      end
      chk("done_latency", cyc - t0, FCYC);
      drive(1'b0, '0, acc);
      chk("ready_after_done", code_ready, 1);
   endtask

   task automatic drain();
      logic acc;
      for (int k = 0; k < 200 && (exp_q.size() != 0 || mon_act); k++) drive(1'b0, '0, acc);
      chk("drain", (exp_q.size() != 0) || mon_act, 0);
   endtask

   // Monitor: every negedge compare line/status against the frame at the head of the queue.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            mon_act = 1'b0;
            chk("reset_state", {tx_line, done, busy, code_ready}, 4'b1001);
         end else begin
            if (!mon_act && busy) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_frame", busy, 0);
               end else begin
                  mon_exp = exp_q.pop_front();
                  mon_act = 1'b1;
                  mon_idx = 0;
               end
            end
            if (mon_act) begin
               chk($sformatf("frame_sample[%0d]", mon_idx), {tx_line, done, busy, code_ready},
                   {mon_exp[mon_idx / DIV], (mon_idx == FCYC - 1), 1'b1, 1'b0});
               mon_idx++;
               if (mon_idx == FCYC) mon_act = 1'b0;
            end else if (!busy) begin
               chk("idle_state", {tx_line, done, busy, code_ready}, 4'b1001);
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned t0, t1;
      logic acc;
      logic [3:0] par_tab = 4'b0110;
      logic [WIDTH-1:0] c;

      // Reset for three clocks, then look at the outputs right after release.
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      #1;
      chk("rst_tx_line", tx_line, 1);
      chk("rst_code_ready", code_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);

      // Single frame 2'b10.
      send(2'b10, t0);
      wait_done(t0);
      idle(2);

      // Parity sweep with an explicit look at the parity bit.
      for (int v = 0; v < 4; v++) begin
         c = WIDTH'(v);
         send(c, t0);
         idle((WIDTH + 1) * DIV + 2);
         chk($sformatf("parity_%0d", v), tx_line, par_tab[c]);
         wait_done(t0);
         idle(1);
      end

      // Back-to-back with code_valid held high.
      send(2'b11, t0);
      send(2'b01, t1);
      chk("b2b_gap", t1 - t0, FCYC + 1);
      idle((WIDTH + 1) * DIV + 2);
      chk("b2b_parity", tx_line, 1);
      wait_done(t1);

      // Valid pulses and code changes during a frame must be ignored.
      send(2'b01, t0);
      idle(2 * DIV);
      drive(1'b1, 2'b10, acc);
      chk("ignored_accept", acc, 0);
      drive(1'b1, 2'b11, acc);
      drive(1'b0, 2'b00, acc);
      wait_done(t0);
      drain();

      // Randomized traffic.
      for (int k = 0; k < 400; k++) drive(($urandom_range(0, 9) < 4), WIDTH'($urandom), acc);
      drain();

      // Reset during the parity bit.
      send(2'b01, t0);
      idle((WIDTH + 1) * DIV + 2);
      @(posedge clk);
      #2 rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("midrst_tx_line", tx_line, 1);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_ready", code_ready, 1);
      repeat (2) @(negedge clk);
      @(negedge clk);
      c = 2'b11;
      code_valid = 1'b1;
      code_in = c;
      #1 rst_n = 1'b1;
      exp_q.push_back(frame_of(c));
      t0 = cyc;
      @(posedge clk);
      #1 chk("accept_after_rst", busy, 1);
      wait_done(t0);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/code_tx.md
# code_tx

Serial transmitter for WIDTH-bit comparison codes. It accepts a parallel code word through a valid/ready handshake and sends it on a single line as a framed bit stream: start bit, data LSB-first, even parity, stop bit. It is the sending end of the code-match path. The matching receiver deserialises the frame, checks parity, and feeds the XNOR/AND equality stage.

## Interface
- WIDTH, default 2: code word width in bits; must be ≥ 1.
- DIV, default 4: clocks per serial bit; must be ≥ 1.

- clk  in  1  sole clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- code_in  in  WIDTH  code word; sampled only on handshake.
- code_valid  in  1  sender has a code word.
- code_ready  out  1  block can accept a word (high only in IDLE).
- tx_line  out  1  serial output; idle level 1.
- busy  out  1  frame in progress (high in every non-IDLE state).
- done  out  1  one-cycle pulse in the last clock of the stop bit.

Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- **IDLE**
  - tx_line=1, code_ready=1.
  - On code_valid & code_ready: latch code_in into shift register, latch parity = XOR of code_in, clear bit-timer and bit index, go to START.
- **START**: tx_line=0 for DIV clocks, then DATA.
- **DATA**
  - tx_line = shift_reg[0] for DIV clocks per bit.
  - Shift right at each bit boundary; bit index counts 0..WIDTH-1.
  - After bit WIDTH-1 go to PARITY.
- **PARITY**: tx_line = latched parity (even: total count of 1s over data+parity is even) for DIV clocks, then STOP.
- **STOP**: tx_line=1 for DIV clocks; done=1 in the final clock; then IDLE.
- Bit timer:
  - counts 0..DIV-1;
  - end-of-bit tick when count = DIV-1;
  - wraps to 0.
  - DIV=1 gives a tick every clock.
- Registers:
  - bit timer is ceil(log2(DIV)) bits, minimum 1;
  - bit index is ceil(log2(WIDTH)) bits, minimum 1.
- code_in and code_valid are ignored outside IDLE. No queueing; a held code_valid is accepted on the next IDLE cycle.
- Reset state: IDLE, tx_line=1, code_ready=1, busy=0, done=0, counters 0, shift register 0.
- Reset mid-frame truncates the frame immediately. tx_line returns to 1 asynchronously and no done pulse is produced.

## Timing
- Handshake cycle T (valid & ready high at edge T).
- Start bit drives tx_line=0 from the edge after T, for DIV clocks.
- Frame length (WIDTH+3)·DIV clocks after acceptance.
- done is high during clock (WIDTH+3)·DIV after acceptance. code_ready is high the following clock.
- Back-to-back: with code_valid held, the next acceptance is at that first IDLE cycle. Inter-frame gap is exactly 1 idle clock at tx_line=1.
- All outputs are registered or decoded from registered state only; no combinational path from code_valid to tx_line. code_ready is a decode of state and does not depend on code_valid.

## Structure
- Package code_link_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - frame constants: START_LVL=0, STOP_LVL=1, IDLE_LVL=1;
  - parity-mode constant: EVEN.
- The receiver imports the same package.
- Sub-module bit_timer (parameter DIV; ports clk, rst_n, clr, tick) generates the per-bit tick. It is reused unchanged by the receiver.

## Test plan
- Reset: hold rst_n=0 for 3 clocks, release → tx_line=1, code_ready=1, busy=0, done=0.
- Single frame, WIDTH=2, DIV=4, code_in=2'b10 → tx_line sequence 0,0,1,1,1 with each level held 4 clocks. That is 20 clocks: start 0, bit0=0, bit1=1, parity=1, stop=1. done pulses on clock 20; code_ready returns on clock 21.
- Parity sweep: codes 00/01/10/11 → parity bits 0/1/1/0.
- Back-to-back: code_valid held high with 2'b11 then 2'b01 → two frames separated by exactly one idle clock. The second frame's parity bit is 1.
- Ignored input: change code_in and pulse code_valid during DATA → transmitted bits unchanged, no extra frame.
- Reset mid-frame: assert rst_n=0 during PARITY → tx_line=1 immediately (asynchronous), no done pulse. After release, a new word is accepted on the first clock.
